// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the two-input gate self-test sequencer.
//   gate_bist_state_t : sequencer FSM states
//   NUM_VEC / IDX_W   : number of exhaustive input vectors and index width
//   TRUTH_*           : expected-output tables indexed by {b,a}
package gate_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        CHECK = 2'd2
    } gate_bist_state_t;

    localparam int unsigned NUM_VEC = 4;
    localparam int unsigned IDX_W   = $clog2(NUM_VEC);
    localparam int unsigned CNT_W   = 4;

    localparam logic [3:0] TRUTH_NAND = 4'b0111;
    localparam logic [3:0] TRUTH_NOR  = 4'b0001;
    localparam logic [3:0] TRUTH_AND  = 4'b1000;
    localparam logic [3:0] TRUTH_OR   = 4'b1110;
    localparam logic [3:0] TRUTH_XOR  = 4'b0110;
    localparam logic [3:0] TRUTH_XNOR = 4'b1001;

endpackage

// File: rtl/gate_bist_seq.sv
// Settle-time and vector-index counters for gate_bist2.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : start accepted, rewind to vector 0
//   hold_en    : FSM is in HOLD, count settle cycles
//   step       : FSM is in CHECK, advance to the next vector
//   idx        : current vector index {b,a}
//   last_cycle : this HOLD cycle is the final settle cycle
//   last_vec   : current vector is the last one
module gate_bist_seq
    import gate_bist_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             hold_en,
    input  logic             step,
    output logic [IDX_W-1:0] idx,
    output logic             last_cycle,
    output logic             last_vec
);

    logic [CNT_W-1:0] cnt;

    // Settle counter restarts for every vector; index saturates at the last vector.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (load) begin
            cnt <= '0;
            idx <= '0;
        end else if (hold_en) begin
            cnt <= last_cycle ? '0 : CNT_W'(cnt + CNT_W'(1));
        end else if (step) begin
            cnt <= '0;
            if (!last_vec) begin
                idx <= IDX_W'(idx + IDX_W'(1));
            end
        end
    end

    assign last_cycle = (cnt == CNT_W'(SETTLE - 1));
    assign last_vec   = (idx == IDX_W'(NUM_VEC - 1));

endmodule

// File: rtl/gate_bist2.sv
// Built-in self-test sequencer for a two-input gate: drives the four
// input vectors, waits SETTLE cycles per vector, checks the gate output
// against TRUTH and reports per-vector strobes plus a final verdict.
//   clk, rst_n          : clock, synchronous active-low reset
//   start               : begin a run (sampled only in IDLE)
//   s                   : output of the gate under test
//   a, b                : registered gate inputs
//   busy                : run in progress
//   chk_valid, chk_ok   : one-cycle check strobe and its result
//   done                : one-cycle end-of-run pulse
//   pass                : verdict, valid from done until the next start
//   err_cnt, fail_idx   : mismatch count and first failing vector
module gate_bist2
    import gate_bist_pkg::*;
#(
    parameter logic [3:0]  TRUTH  = TRUTH_NAND,
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       s,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       chk_valid,
    output logic       chk_ok,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [1:0] fail_idx
);

    if (SETTLE == 0 || SETTLE > 15) begin : g_settle_range
        $error("gate_bist2: SETTLE must be in 1..15");
    end

    gate_bist_state_t state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] next_idx;
    logic             last_cycle;
    logic             last_vec;
    logic             load;
    logic             hold_en;
    logic             step;
    logic             match;

    assign load     = (state == IDLE) && start;
    assign hold_en  = (state == HOLD);
    assign step     = (state == CHECK);
    assign next_idx = IDX_W'(idx + IDX_W'(1));

    // Case equality so an undriven or unknown gate output counts as a mismatch.
    assign match = (s === TRUTH[idx]);

    gate_bist_seq #(
        .SETTLE (SETTLE)
    ) u_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .hold_en    (hold_en),
        .step       (step),
        .idx        (idx),
        .last_cycle (last_cycle),
        .last_vec   (last_vec)
    );

    // Sequencer FSM with registered stimulus and result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            chk_valid <= 1'b0;
            chk_ok    <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= 3'd0;
            fail_idx  <= 2'd0;
        end else begin
            chk_valid <= 1'b0;
            chk_ok    <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= HOLD;
                        a        <= 1'b0;
                        b        <= 1'b0;
                        busy     <= 1'b1;
                        pass     <= 1'b0;
                        err_cnt  <= 3'd0;
                        fail_idx <= 2'd0;
                    end
                end
                HOLD: begin
                    if (last_cycle) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    chk_valid <= 1'b1;
                    chk_ok    <= match;
                    if (!match) begin
                        err_cnt <= 3'(err_cnt + 3'd1);
                        if (err_cnt == 3'd0) begin
                            fail_idx <= 2'(idx);
                        end
                    end
                    if (last_vec) begin
                        state <= IDLE;
                        a     <= 1'b0;
                        b     <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_cnt == 3'd0) && match;
                    end else begin
                        state <= HOLD;
                        a     <= next_idx[0];
                        b     <= next_idx[1];
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/gate_bist2.md
# gate_bist2

Synchronous built-in self-test sequencer for any two-input primitive gate in the library (`gate_nand`, `gate_nor`, etc.). It drives the four input vectors in a fixed order into a gate under test and waits a programmable settle time. It then samples the gate output, compares it with a parameterised truth table, and reports a per-vector ok/fail strobe and a final verdict. The block is the in-hardware counterpart of the per-gate stimulus/check benches, for use in self-checking builds and on FPGA.

## Interface
- `TRUTH`, 4'b0111, expected gate output indexed by vector index `{b,a}`; the default is NAND.
- `SETTLE`, 2, cycles each vector is held before sampling; legal range 1..15, elaboration error otherwise.
- `clk`  in  1  single clock, all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `s`  in  1  output of the gate under test.
- `a`  out  1  gate input a (registered).
- `b`  out  1  gate input b (registered).
- `busy`  out  1  run in progress.
- `chk_valid`  out  1  one-cycle strobe: a vector was just checked.
- `chk_ok`  out  1  result of that check; valid only with `chk_valid`.
- `done`  out  1  one-cycle pulse at end of run.
- `pass`  out  1  verdict, 1 iff `err_cnt == 0`; valid from `done` until the next accepted `start`.
- `err_cnt`  out  3  count of mismatching vectors, 0..4.
- `fail_idx`  out  2  index of the first mismatching vector; 0 if none, qualify with `!pass`.

## Operation
- Clock and reset: one clock domain; reset is synchronous and active-low.
- Reset values: all outputs are 0 (`a`, `b`, `busy`, `chk_valid`, `chk_ok`, `done`, `pass`, `err_cnt`, `fail_idx`). State is IDLE.
- FSM states: IDLE, HOLD, CHECK.
  - IDLE → HOLD when `start`=1.
  - HOLD → CHECK after `SETTLE` cycles in HOLD, counting the entry cycle.
  - CHECK → HOLD when the vector index < 3.
  - CHECK → IDLE when the vector index = 3.
- Vector order, as index = `{b,a}`: 0 (a=0,b=0), 1 (a=1,b=0), 2 (a=0,b=1), 3 (a=1,b=1). The index is a 2-bit counter; it never wraps mid-run.
- Accepting `start`:
  - loads vector 0 onto `a`/`b`;
  - clears `err_cnt`, `fail_idx` and `pass`;
  - sets `busy`.
- In CHECK, `s` is compared with `TRUTH[idx]`. Any value of `s` other than the exact expected bit (including X/Z in simulation) is a mismatch.
- On a mismatch:
  - `err_cnt` increments;
  - if this is the first mismatch of the run, `fail_idx` is set to `idx`.
- `start` is ignored while busy. When held high continuously, runs go back to back.
- Reset mid-run: at the next edge every output returns to its reset value, no `done` is issued, and the partial results are discarded.

## Timing
- Cycle 0 is the edge where `start` is sampled in IDLE.
- Vector k is on `a`/`b` during cycles 1+k·(SETTLE+1) through (k+1)·(SETTLE+1).
- `s` is sampled at the closing edge of the last cycle of each vector; that cycle is CHECK.
- `chk_valid` and `chk_ok` are high in the first cycle of the next vector's window, i.e. cycle 1+(k+1)·(SETTLE+1).
- Run end, last vector (k=3):
  - `done` is high in cycle 4·(SETTLE+1)+1, together with the final `chk_valid`;
  - `busy` falls in that same cycle;
  - `pass`, `err_cnt` and `fail_idx` are final in that cycle and hold afterwards.
- `a`/`b` return to 0 when `done` is high.
- Total run length is 4·(SETTLE+1) busy cycles. With SETTLE=2: vectors occupy cycles 1–3, 4–6, 7–9 and 10–12, and `done` is in cycle 13.
- A `start` sampled in the `done` cycle (state IDLE) is accepted; the next run's vector 0 appears in the following cycle.

## Structure
- Package `gate_bist_pkg` holds:
  - the state enum (IDLE, HOLD, CHECK);
  - `NUM_VEC` = 4;
  - truth constants: `TRUTH_NAND` 4'b0111, `TRUTH_NOR` 4'b0001, `TRUTH_AND` 4'b1000, `TRUTH_OR` 4'b1110, `TRUTH_XOR` 4'b0110, `TRUTH_XNOR` 4'b1001.
- One sub-module, `gate_bist_seq`, contains the settle counter and vector index counter. It outputs `idx`, `last_cycle` and `last_vec`.
- The top level contains the FSM, the comparator and the result registers.

## Test plan
- `TRUTH_NAND`, SETTLE=2, real `gate_nand`, `start` pulsed at cycle 0 → four `chk_ok`=1 strobes at cycles 4, 7, 10 and 13; `done` at cycle 13 with `pass`=1, `err_cnt`=0.
- Same setup but `s` forced to 1 → only vector 3 fails; `err_cnt`=1, `fail_idx`=3, `pass`=0.
- `TRUTH_AND` against `gate_nand` → all four vectors fail; `err_cnt`=4, `fail_idx`=0.
- `rst_n` low at cycle 6 of a run → all outputs 0 at cycle 7 and no `done`. A new `start` then completes normally with `pass`=1.
- `start` held high continuously, SETTLE=1 → `done` at cycles 9, 18, 27, …; `a`/`b` show vector 0 at cycles 10 and 19. `start` pulses while `busy` have no effect.
- `s` driven X during vector 1 → `chk_ok`=0 for that vector; `err_cnt`=1, `fail_idx`=1.
